// File: rtl/ipfilter_pkg.sv
// ipfilter_pkg: shared state encoding, header depth, rule type and helpers for the IP filter gate
package ipfilter_pkg;
    localparam int HDR_BEATS = 5;
    typedef enum logic [2:0] {IDLE, BUFFER, WAIT, FLUSH, PASS, DROP} state_t;
    typedef struct packed {
        logic        en;
        logic        dir;
        logic [31:0] addr;
        logic [31:0] mask;
    } rule_t;
    function automatic logic rule_hit(rule_t r, logic [31:0] src, logic [31:0] dst);
        return r.en && (((r.dir ? dst : src) & r.mask) == (r.addr & r.mask));
    endfunction
    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/ipfilter_rule_match.sv
// ipfilter_rule_match: OR of all enabled address/mask rule hits against the parsed src/dst addresses
module ipfilter_rule_match
    import ipfilter_pkg::*;
#(
    parameter int NUM_RULES = 4
) (
    input  rule_t [NUM_RULES-1:0] rules,
    input  logic  [31:0]          src,
    input  logic  [31:0]          dst,
    output logic                  hit
);
    // any single matching rule is enough to flag the packet
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_RULES; i++)
            hit = hit | rule_hit(rules[i], src, dst);
    end
endmodule

// File: rtl/ipfilter_gate.sv
// ipfilter_gate: holds the first header beats of each packet until the parser result decides pass or drop
module ipfilter_gate
    import ipfilter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RULES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic                    result_vld,
    input  logic                    ipv4,
    input  logic [31:0]             ipv4_src_addr,
    input  logic [31:0]             ipv4_dst_addr,
    input  logic [NUM_RULES-1:0]    rule_en,
    input  logic [NUM_RULES-1:0]    rule_dir,
    input  logic [NUM_RULES*32-1:0] rule_addr,
    input  logic [NUM_RULES*32-1:0] rule_mask,
    output logic [31:0]             pkt_pass_cnt,
    output logic [31:0]             pkt_drop_cnt
);
    state_t                  state;
    logic [DATA_WIDTH-1:0]   hdr_data [HDR_BEATS];
    logic [DATA_WIDTH/8-1:0] hdr_keep [HDR_BEATS];
    logic [HDR_BEATS-1:0]    hdr_last;
    logic [2:0]              cnt;
    logic [2:0]              rd;
    rule_t [NUM_RULES-1:0]   rules;
    logic                    hit;
    logic                    drop;
    logic                    s_hs;
    logic                    m_hs;

    for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
        assign rules[i] = {rule_en[i], rule_dir[i], rule_addr[32*i +: 32], rule_mask[32*i +: 32]};
    end

    ipfilter_rule_match #(.NUM_RULES(NUM_RULES)) u_match (
        .rules (rules),
        .src   (ipv4_src_addr),
        .dst   (ipv4_dst_addr),
        .hit   (hit)
    );

    assign drop          = result_vld && ipv4 && hit;
    assign s_axis_tready = !rst && (state == IDLE || state == BUFFER || state == DROP ||
                                    (state == PASS && m_axis_tready));
    assign m_axis_tvalid = !rst && (state == FLUSH || (state == PASS && s_axis_tvalid));
    assign m_axis_tdata  = state == PASS ? s_axis_tdata : hdr_data[rd];
    assign m_axis_tkeep  = state == PASS ? s_axis_tkeep : hdr_keep[rd];
    assign m_axis_tlast  = state == PASS ? s_axis_tlast : hdr_last[rd];
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = m_axis_tvalid && m_axis_tready;

    // packet FSM: capture header, decide once in WAIT, then replay, forward or discard
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rd           <= '0;
            pkt_pass_cnt <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            case (state)
                IDLE, BUFFER: if (s_hs) begin
                    hdr_data[cnt] <= s_axis_tdata;
                    hdr_keep[cnt] <= s_axis_tkeep;
                    hdr_last[cnt] <= s_axis_tlast;
                    cnt           <= cnt + 3'd1;
                    if (cnt == 3'(HDR_BEATS - 1)) begin
                        state <= WAIT;
                    end else if (s_axis_tlast) begin
                        state        <= FLUSH;
                        pkt_pass_cnt <= sat_inc(pkt_pass_cnt);
                    end else begin
                        state <= BUFFER;
                    end
                end
                WAIT: if (drop) begin
                    pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
                    cnt          <= '0;
                    state        <= hdr_last[HDR_BEATS-1] ? IDLE : DROP;
                end else begin
                    pkt_pass_cnt <= sat_inc(pkt_pass_cnt);
                    state        <= FLUSH;
                end
                FLUSH: if (m_hs) begin
                    rd <= rd + 3'd1;
                    if (rd == cnt - 3'd1) begin
                        rd    <= '0;
                        cnt   <= '0;
                        state <= hdr_last[rd] ? IDLE : PASS;
                    end
                end
                PASS, DROP: if (s_hs && s_axis_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ipfilter_gate.md
IPFILTER_GATE -- requirements
Module: ipfilter_gate

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, beat width in bits; only 64 supported.
REQ-002 SHALL have parameter NUM_RULES, default 4, rule table entries; legal range 1..16.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tdata/tkeep/tvalid/tlast  in  64/8/1/1  packet input, network byte order.
- s_axis_tready  out  1  input ready; also drives the tready tap of the upstream parser.
- m_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  filtered packet output.
- m_axis_tready  in  1  output ready.
- result_vld, ipv4  in  1/1  parser one-shot result, ipv4 flag.
- ipv4_src_addr, ipv4_dst_addr  in  32/32  parser addresses.
- rule_en  in  NUM_RULES  per-rule enable.
- rule_dir  in  NUM_RULES  0 = match source, 1 = match destination.
- rule_addr, rule_mask  in  NUM_RULES*32 each  rule i at bits [32*i +: 32].
- pkt_pass_cnt, pkt_drop_cnt  out  32/32  saturating packet counters.

Function
REQ-004 SHALL implement states IDLE, BUFFER, WAIT, FLUSH, PASS, DROP; IDLE moves to BUFFER on the first accepted beat.
REQ-005 SHALL store the first five accepted beats of each packet (data, keep, last) in a 5-entry header buffer; s_axis_tready = 1 in IDLE and BUFFER.
REQ-006 SHALL, on acceptance of beat index 4 without tlast, enter WAIT with s_axis_tready = 0.
REQ-007 SHALL also enter WAIT when beat index 4 carries tlast (exact 5-beat packet).
REQ-008 SHALL, when tlast is accepted at beat index 0..3, skip WAIT, enter FLUSH and pass the packet unfiltered.
REQ-009 SHALL stay in WAIT exactly one cycle; result_vld is expected in that cycle.
REQ-010 SHALL, in WAIT with result_vld = 1, drop when ipv4 = 1 and any rule i hits; rule i hits when rule_en[i] = 1 and (A & rule_mask[i]) == (rule_addr[i] & rule_mask[i]), where A = ipv4_src_addr if rule_dir[i] = 0, else ipv4_dst_addr.
REQ-011 SHALL pass the packet when ipv4 = 0, when no rule hits, or when result_vld = 0 in the WAIT cycle.
REQ-012 SHALL sample rule inputs only in the WAIT cycle; later rule changes do not affect a decided packet.
REQ-013 SHALL, in FLUSH, present buffered beats in order on m_axis with m_axis_tvalid = 1 and s_axis_tready = 0, advancing only on m_axis handshake.
REQ-014 SHALL, after the last buffered beat is accepted, go to IDLE if that beat had tlast, else to PASS.
REQ-015 SHALL, in PASS, connect s_axis to m_axis combinationally (s_axis_tready = m_axis_tready; tvalid, data, keep, last forwarded) and return to IDLE on the tlast handshake.
REQ-016 SHALL, on a drop decision, discard the buffer and go to IDLE if the buffered beat 4 had tlast; otherwise enter DROP.
REQ-017 SHALL, in DROP, hold s_axis_tready = 1 and m_axis_tvalid = 0, discard beats, and return to IDLE on the tlast handshake.
REQ-018 SHALL never present a partial dropped packet on m_axis; passed packets are bit-identical to the input.
REQ-019 SHALL increment pkt_pass_cnt or pkt_drop_cnt by 1 once per packet, at decision time; short packets count as pass; both counters saturate at 0xFFFFFFFF.
REQ-020 SHALL add at most one cycle of latency per beat through the buffer path and zero cycles in PASS.

Reset
REQ-021 SHALL, while rst = 1 at a clock edge, set state IDLE, buffer count 0, m_axis_tvalid 0, s_axis_tready 0, and both counters 0.
REQ-022 SHALL abandon any packet in progress on reset mid-packet; after reset, the next beat is treated as beat 0.

Structure
REQ-023 SHALL place the state enum, HDR_BEATS = 5 and a rule struct {en, dir, addr, mask} in shared package ipfilter_pkg.
REQ-024 SHALL implement the rule compare as combinational sub-module ipfilter_rule_match (NUM_RULES rules plus src/dst in, hit out).

Verification
REQ-025 SHALL cover: 8-beat IPv4 packet, src 10.0.0.5; rule0 en, dir 0, addr 10.0.0.0, mask 255.255.255.0 -> no m_axis beats; pkt_drop_cnt = 1.
REQ-026 SHALL cover: same packet with rule0 disabled -> 8 identical beats out; pkt_pass_cnt = 1.
REQ-027 SHALL cover: 3-beat packet -> 3 beats out unchanged, WAIT never entered, pkt_pass_cnt = 1.
REQ-028 SHALL cover: non-IPv4 packet (ethertype 0x86DD) matching rule addresses -> passed; exact 5-beat dropped IPv4 packet -> IDLE with no DROP state.
REQ-029 SHALL cover: random m_axis_tready backpressure (50%) over 100 mixed packets -> output equals scoreboard and counters sum to 100.
REQ-030 SHALL cover: rst asserted in FLUSH -> m_axis_tvalid = 0 the next cycle; the following packet is handled correctly.
